// File: rtl/alu4_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu4_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Common 74181-style select/mode encodings (active-high data)
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_SUB   = 4'b0110;
  localparam logic [3:0] S_AND   = 4'b1011;
  localparam logic [3:0] S_OR    = 4'b1110;
  localparam logic       M_ARITH = 1'b0;
  localparam logic       M_LOGIC = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu4_seq_ctrl.sv
// Sequencer FSM and nibble counter for alu4_seq: request/response handshakes
// and per-cycle capture strobes for the datapath.
module alu4_seq_ctrl
  import alu4_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic rsp_ready,
  output logic req_ready,
  output logic rsp_valid,
  output logic accept_c,
  output logic cap_c,
  output logic last_c
);

  localparam int unsigned IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    accept_c    = 1'b0;
    cap_c       = 1'b0;
    last_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c    = 1'b1;
          state_d     = RUN;
          idx_d       = '0;
          req_ready_d = 1'b0;
        end
      end
      RUN: begin
        cap_c = 1'b1;
        if (idx_q == IDX_LAST) begin
          last_c      = 1'b1;
          state_d     = DONE;
          idx_d       = '0;
          rsp_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: rtl/alu4_seq.sv
// Multi-cycle N-bit ALU sequencer driving one external 4-bit slice, LSB nibble first.
// Optional zero flag output rsp_z when ALU4_SEQ_ZERO_EN is defined.
module alu4_seq
  import alu4_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req_a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   req_b,
  input  logic [3:0]                    req_s,
  input  logic                          req_m,
  input  logic                          req_cn,
  output logic [3:0]                    sl_a,
  output logic [3:0]                    sl_b,
  output logic [3:0]                    sl_s,
  output logic                          sl_m,
  output logic                          sl_cn,
  input  logic [3:0]                    sl_f,
  input  logic                          sl_cn4,
  input  logic                          sl_ab,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   rsp_f,
  output logic                          rsp_cn,
  output logic                          rsp_ab
`ifdef ALU4_SEQ_ZERO_EN
  ,
  output logic                          rsp_z
`endif
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned RES_W = W - NIBBLE_W;

  logic accept_c, cap_c, last_c;

  alu4_seq_ctrl #(.NIBBLES(NIBBLES)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .rsp_ready (rsp_ready),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .accept_c  (accept_c),
    .cap_c     (cap_c),
    .last_c    (last_c)
  );

  // Operands shift down one nibble per RUN cycle so the slice always sees bits [3:0];
  // after the last nibble they are all zero, which keeps sl_a/sl_b quiet outside RUN.
  logic [W-1:0]     a_sh_q, a_sh_d;
  logic [W-1:0]     b_sh_q, b_sh_d;
  logic [3:0]       sl_s_q, sl_s_d;
  logic             sl_m_q, sl_m_d;
  logic             sl_cn_q, sl_cn_d;
  logic             ab_acc_q, ab_acc_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [W-1:0]     rsp_f_q, rsp_f_d;
  logic             rsp_cn_q, rsp_cn_d;
  logic             rsp_ab_q, rsp_ab_d;
`ifdef ALU4_SEQ_ZERO_EN
  logic             rsp_z_q, rsp_z_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sl_s_q   <= '0;
      sl_m_q   <= 1'b0;
      sl_cn_q  <= 1'b0;
      ab_acc_q <= 1'b0;
      res_q    <= '0;
      rsp_f_q  <= '0;
      rsp_cn_q <= 1'b0;
      rsp_ab_q <= 1'b0;
`ifdef ALU4_SEQ_ZERO_EN
      rsp_z_q  <= 1'b0;
`endif
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sl_s_q   <= sl_s_d;
      sl_m_q   <= sl_m_d;
      sl_cn_q  <= sl_cn_d;
      ab_acc_q <= ab_acc_d;
      res_q    <= res_d;
      rsp_f_q  <= rsp_f_d;
      rsp_cn_q <= rsp_cn_d;
      rsp_ab_q <= rsp_ab_d;
`ifdef ALU4_SEQ_ZERO_EN
      rsp_z_q  <= rsp_z_d;
`endif
    end
  end

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sl_s_d   = sl_s_q;
    sl_m_d   = sl_m_q;
    sl_cn_d  = sl_cn_q;
    ab_acc_d = ab_acc_q;
    res_d    = res_q;
    rsp_f_d  = rsp_f_q;
    rsp_cn_d = rsp_cn_q;
    rsp_ab_d = rsp_ab_q;
`ifdef ALU4_SEQ_ZERO_EN
    rsp_z_d  = rsp_z_q;
`endif
    if (accept_c) begin
      a_sh_d   = req_a;
      b_sh_d   = req_b;
      sl_s_d   = req_s;
      sl_m_d   = req_m;
      sl_cn_d  = req_cn;
      ab_acc_d = 1'b1;
    end else if (cap_c) begin
      a_sh_d   = a_sh_q >> NIBBLE_W;
      b_sh_d   = b_sh_q >> NIBBLE_W;
      ab_acc_d = ab_acc_q & sl_ab;
      // Partial result fills from the top; the final nibble completes it
      res_d    = RES_W'({sl_f, res_q} >> NIBBLE_W);
      sl_cn_d  = sl_cn4;
      if (last_c) begin
        sl_s_d   = '0;
        sl_m_d   = 1'b0;
        sl_cn_d  = 1'b0;
        rsp_f_d  = {sl_f, res_q};
        rsp_cn_d = sl_cn4;
        rsp_ab_d = ab_acc_q & sl_ab;
`ifdef ALU4_SEQ_ZERO_EN
        rsp_z_d  = ({sl_f, res_q} == '0);
`endif
      end
    end
  end

  assign sl_a   = a_sh_q[NIBBLE_W-1:0];
  assign sl_b   = b_sh_q[NIBBLE_W-1:0];
  assign sl_s   = sl_s_q;
  assign sl_m   = sl_m_q;
  assign sl_cn  = sl_cn_q;
  assign rsp_f  = rsp_f_q;
  assign rsp_cn = rsp_cn_q;
  assign rsp_ab = rsp_ab_q;
`ifdef ALU4_SEQ_ZERO_EN
  assign rsp_z  = rsp_z_q;
`endif

endmodule
